// File: rtl/nx_mesh_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nx_mesh_ctrl
// Purpose  : Run controller for the node mesh. On a host start it issues a
//            programmed number of single-cycle trigger pulses. Before every
//            pulse it waits for IDLE_CYCLES consecutive quiet mesh cycles.
//            It also gates the host inbound stream so that no beat enters
//            the mesh on a trigger cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   NX_MESH_CTRL_TIMEOUT_EN - when defined, a SETTLE watchdog of
//                             TIMEOUT_CYCLES ends the run and sets error_o.
//                             When undefined, error_o is tied to 0.
// ----------------------------------------------------------------------------
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   start_i, stop_i      run start (IDLE only) / early termination request
//   cycles_i             trigger target, 0 = free-run, captured on start
//   mesh_busy_i          any valid inside the mesh or on its outbound stream
//   host_data_i/valid_i  host inbound stream in; host_ready_o back to host
//   mesh_data_o/valid_o  stream to mesh inbound; mesh_ready_i from mesh
//   trigger_o            single-cycle trigger to all nodes
//   active_o             run in progress (SETTLE or TRIGGER)
//   done_o               single-cycle pulse at run end
//   cycle_count_o        triggers issued in the current or last run
//   error_o              sticky watchdog flag
// ============================================================================
module nx_mesh_ctrl #(
   parameter int STREAM_WIDTH   = 32,
   parameter int CYCLE_WIDTH    = 24,
   parameter int IDLE_CYCLES    = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic                    stop_i,
   input  logic [CYCLE_WIDTH-1:0]  cycles_i,
   input  logic                    mesh_busy_i,
   input  logic [STREAM_WIDTH-1:0] host_data_i,
   input  logic                    host_valid_i,
   output logic                    host_ready_o,
   output logic [STREAM_WIDTH-1:0] mesh_data_o,
   output logic                    mesh_valid_o,
   input  logic                    mesh_ready_i,
   output logic                    trigger_o,
   output logic                    active_o,
   output logic                    done_o,
   output logic [CYCLE_WIDTH-1:0]  cycle_count_o,
   output logic                    error_o
);

   localparam int c_quiet_w = $clog2(IDLE_CYCLES + 1);
   localparam logic [c_quiet_w-1:0] c_quiet_last = c_quiet_w'(IDLE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETTLE  = 2'd1,
      S_TRIGGER = 2'd2
   } state_t;

   state_t                 r_state;
   logic [c_quiet_w-1:0]   r_quiet;
   logic [CYCLE_WIDTH-1:0] r_target;

   logic                   w_quiet;
   logic                   w_fire;
   logic                   w_timeout;
   logic [CYCLE_WIDTH-1:0] w_count_next;

   if (IDLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("nx_mesh_ctrl: IDLE_CYCLES and TIMEOUT_CYCLES must be >= 1");
   end

   // Stream gate: combinational pass-through, closed only while trigger_o is
   // high. A held host beat simply sees ready low and retries next cycle.
   assign mesh_data_o  = host_data_i;
   assign mesh_valid_o = host_valid_i & ~trigger_o;
   assign host_ready_o = mesh_ready_i & ~trigger_o;

   // A host handshake counts as traffic just like internal mesh activity.
   assign w_quiet      = ~mesh_busy_i & ~(mesh_valid_o & mesh_ready_i);
   assign w_fire       = w_quiet && (r_quiet == c_quiet_last);
   assign w_count_next = cycle_count_o + CYCLE_WIDTH'(1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state       <= S_IDLE;
         r_quiet       <= '0;
         r_target      <= '0;
         trigger_o     <= 1'b0;
         done_o        <= 1'b0;
         active_o      <= 1'b0;
         cycle_count_o <= '0;
      end else begin
         trigger_o <= 1'b0;
         done_o    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_state       <= S_SETTLE;
                  active_o      <= 1'b1;
                  r_target      <= cycles_i;
                  cycle_count_o <= '0;
                  r_quiet       <= '0;
               end
            end
            S_SETTLE: begin
               // stop beats a pending trigger; a trigger beats the watchdog
               if (stop_i) begin
                  r_state  <= S_IDLE;
                  active_o <= 1'b0;
                  done_o   <= 1'b1;
               end else if (w_fire) begin
                  r_state   <= S_TRIGGER;
                  trigger_o <= 1'b1;
                  r_quiet   <= '0;
               end else if (w_timeout) begin
                  r_state  <= S_IDLE;
                  active_o <= 1'b0;
                  done_o   <= 1'b1;
               end else if (w_quiet) begin
                  r_quiet <= r_quiet + c_quiet_w'(1);
               end else begin
                  r_quiet <= '0;
               end
            end
            S_TRIGGER: begin
               cycle_count_o <= w_count_next;
               // A zero target never matches, so free-run wraps silently.
               if (((r_target != '0) && (w_count_next == r_target)) || stop_i) begin
                  r_state  <= S_IDLE;
                  active_o <= 1'b0;
                  done_o   <= 1'b1;
               end else begin
                  r_state <= S_SETTLE;
                  r_quiet <= '0;
               end
            end
            default: begin
               r_state  <= S_IDLE;
               active_o <= 1'b0;
            end
         endcase
      end
   end

`ifdef NX_MESH_CTRL_TIMEOUT_EN
   localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

   logic [c_tmo_w-1:0] r_settle_cnt;
   logic               r_error;

   // Counter holds 0 outside SETTLE, so each SETTLE entry starts from 0.
   // w_timeout is raised during the TIMEOUT_CYCLES-th SETTLE cycle.
   assign w_timeout = (r_settle_cnt == c_tmo_last);
   assign error_o   = r_error;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_settle_cnt <= '0;
         r_error      <= 1'b0;
      end else begin
         if (r_state == S_SETTLE) begin
            r_settle_cnt <= r_settle_cnt + c_tmo_w'(1);
         end else begin
            r_settle_cnt <= '0;
         end
         if (r_state == S_IDLE && start_i) begin
            r_error <= 1'b0;
         end else if (r_state == S_SETTLE && !stop_i && !w_fire && w_timeout) begin
            r_error <= 1'b1;
         end
      end
   end
`else
   // Watchdog not built: SETTLE may wait indefinitely.
   assign w_timeout = 1'b0;
   assign error_o   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nx_mesh_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nx_mesh_ctrl
// Purpose  : Self-checking bench for nx_mesh_ctrl (IDLE_CYCLES=4,
//            CYCLE_WIDTH=3, TIMEOUT_CYCLES=16). Cycle c is the cycle whose
//            closing rising edge is edge c; the start command is applied in
//            cycle 0. Outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nx_mesh_ctrl;

   localparam int SW = 32;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, stop, busy, host_valid, mesh_ready;
   logic [CW-1:0] cycles;
   logic [SW-1:0] host_data;
   logic          host_ready, mesh_valid, trigger, active, done, error;
   logic [SW-1:0] mesh_data;
   logic [CW-1:0] cycle_count;

   int n_pass  = 0;
   int n_total = 0;
   int n_beats = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (mesh_valid && mesh_ready) n_beats++;

   nx_mesh_ctrl #(
      .STREAM_WIDTH  (SW),
      .CYCLE_WIDTH   (CW),
      .IDLE_CYCLES   (4),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .stop_i       (stop),
      .cycles_i     (cycles),
      .mesh_busy_i  (busy),
      .host_data_i  (host_data),
      .host_valid_i (host_valid),
      .host_ready_o (host_ready),
      .mesh_data_o  (mesh_data),
      .mesh_valid_o (mesh_valid),
      .mesh_ready_i (mesh_ready),
      .trigger_o    (trigger),
      .active_o     (active),
      .done_o       (done),
      .cycle_count_o(cycle_count),
      .error_o      (error)
   );

   task automatic chk(input string name, input int cyc, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
   endtask

   typedef struct {
      logic [CW-1:0] target;
      int            busy_lo;
      int            busy_hi;
      int            n_cyc;
      logic [31:0]   trig_mask;
      int            done_cyc;
      logic [CW-1:0] exp_count;
   } run_t;

   run_t runs [4];

   initial begin
      // target, busy window, length, trigger cycles, done cycle, final count
      runs[0] = '{3'd3, 1, 0, 20, 32'h0000_8420, 16, 3'd3}; // triggers 5,10,15
      runs[1] = '{3'd1, 1, 6, 16, 32'h0000_0800, 12, 3'd1}; // trigger 11
      runs[2] = '{3'd2, 3, 3, 18, 32'h0000_2100, 14, 3'd2}; // triggers 8,13
      runs[3] = '{3'd1, 4, 4, 14, 32'h0000_0200, 10, 3'd1}; // trigger 9

      rst = 1'b1; start = 1'b0; stop = 1'b0; busy = 1'b0; cycles = '0;
      host_valid = 1'b0; host_data = '0; mesh_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_trigger", 0, 32'(trigger), 32'd0);
      chk("rst_done",    0, 32'(done),    32'd0);
      chk("rst_active",  0, 32'(active),  32'd0);
      chk("rst_count",   0, 32'(cycle_count), 32'd0);
      chk("rst_error",   0, 32'(error),   32'd0);
      rst = 1'b0;
      @(negedge clk);

      // ---------------- table-driven runs ----------------
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < runs[r].n_cyc; c++) begin
            chk("run_trigger", c, 32'(trigger), 32'(runs[r].trig_mask[c]));
            chk("run_done",    c, 32'(done),    32'(c == runs[r].done_cyc));
            chk("run_active",  c, 32'(active),  32'(c >= 1 && c < runs[r].done_cyc));
            if (c == runs[r].n_cyc - 1) begin
               chk("run_count", c, 32'(cycle_count), 32'(runs[r].exp_count));
               chk("run_error", c, 32'(error), 32'd0);
            end
            start  = (c == 0);
            cycles = runs[r].target;
            busy   = (c >= runs[r].busy_lo && c <= runs[r].busy_hi);
            @(negedge clk);
         end
         start = 1'b0; busy = 1'b0;
      end

      // ---------------- stream gate ----------------
      host_valid = 1'b1; mesh_ready = 1'b0; host_data = 32'h1234_5678;
      #1;
      chk("gate_idle_valid", 0, 32'(mesh_valid), 32'd1);
      chk("gate_idle_ready", 0, 32'(host_ready), 32'd0);
      chk("gate_idle_data",  0, mesh_data, 32'h1234_5678);
      host_valid = 1'b0; mesh_ready = 1'b1;
      @(negedge clk);
      for (int c = 0; c < 9; c++) begin
         start  = (c == 0);
         cycles = 3'd1;
         if (c == 5) begin
            host_valid = 1'b1; host_data = 32'hDEAD_BEEF;
            n_beats = 0;
            #1;
            chk("gate_trig",       c, 32'(trigger),    32'd1);
            chk("gate_trig_valid", c, 32'(mesh_valid), 32'd0);
            chk("gate_trig_ready", c, 32'(host_ready), 32'd0);
         end else if (c == 6) begin
            #1;
            chk("gate_post_valid", c, 32'(mesh_valid), 32'd1);
            chk("gate_post_ready", c, 32'(host_ready), 32'd1);
            chk("gate_post_data",  c, mesh_data, 32'hDEAD_BEEF);
            chk("gate_done",       c, 32'(done), 32'd1);
         end else if (c == 7) begin
            host_valid = 1'b0;
         end else if (c == 8) begin
            chk("gate_beats", c, 32'(n_beats), 32'd1);
         end
         @(negedge clk);
      end
      start = 1'b0;

      // ------- free-run with wrap, start while active, stop in SETTLE -------
      for (int c = 0; c < 51; c++) begin
         chk("fr_trigger", c, 32'(trigger), 32'(c > 0 && c <= 40 && c % 5 == 0));
         chk("fr_done",    c, 32'(done),    32'(c == 44));
         chk("fr_active",  c, 32'(active),  32'(c >= 1 && c < 44));
         if (c == 16) chk("fr_count_3", c, 32'(cycle_count), 32'd3);
         if (c == 36) chk("fr_count_7", c, 32'(cycle_count), 32'd7);
         if (c == 41) chk("fr_wrap_0",  c, 32'(cycle_count), 32'd0);
         start  = (c == 0 || c == 12 || c == 15);
         cycles = (c == 0) ? 3'd0 : 3'd1;
         stop   = (c == 43);
         @(negedge clk);
      end
      start = 1'b0; stop = 1'b0;

      // ---------------- reset during SETTLE ----------------
      for (int c = 0; c < 14; c++) begin
         if (c == 6) chk("rs_count_pre", c, 32'(cycle_count), 32'd1);
         if (c == 8) begin
            chk("rs_active", c, 32'(active),      32'd0);
            chk("rs_count",  c, 32'(cycle_count), 32'd0);
            chk("rs_error",  c, 32'(error),       32'd0);
         end
         if (c >= 8) begin
            chk("rs_trigger", c, 32'(trigger), 32'd0);
            chk("rs_done",    c, 32'(done),    32'd0);
         end
         start  = (c == 0);
         cycles = 3'd0;
         rst    = (c == 7);
         @(negedge clk);
      end
      rst = 1'b0;

`ifdef NX_MESH_CTRL_TIMEOUT_EN
      // ---------------- watchdog: SETTLE cycles 1..16, done in 17 ----------------
      for (int c = 0; c < 20; c++) begin
         chk("to_trigger", c, 32'(trigger), 32'd0);
         chk("to_done",    c, 32'(done),    32'(c == 17));
         chk("to_error",   c, 32'(error),   32'(c >= 17));
         chk("to_active",  c, 32'(active),  32'(c >= 1 && c < 17));
         start  = (c == 0);
         cycles = 3'd1;
         busy   = (c >= 1);
         @(negedge clk);
      end
      busy = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) chk("to_error_clr", c, 32'(error), 32'd0);
         start = (c == 0);
         @(negedge clk);
      end
      start = 1'b0;
      repeat (12) @(negedge clk);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
